// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state and memory-arbiter FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM model handshake as seen by the arbiter.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state; the grant is decided in IDLE and held until completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    INSTR  = 2'd2,
    SCFAIL = 2'd3
  } arb_state_t;

  localparam int BURST_W = 4;

endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the address of the last LL and reports whether an SC may proceed.
// Latency: link updates one cycle after a completion; sc_ok is combinational from the current link.
// Backpressure: none; every completion strobe is absorbed in the cycle it arrives.
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   ll_done      LL completed this cycle (sets link to ll_addr)
//   ll_addr      address of the completing LL
//   wr_done      a store (SW or SC) completed this cycle
//   wr_addr      address of the store / of the SC being evaluated
//   sc_done      SC completed or failed this cycle (always breaks the link)
//   sc_ok        link is valid and matches wr_addr
module ll_sc_link
  import cpu_types_pkg::*;
#(
  parameter bit LINK_EN = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ll_done,
  input  word_t ll_addr,
  input  logic  wr_done,
  input  word_t wr_addr,
  input  logic  sc_done,
  output logic  sc_ok
);

  logic  link_valid_q, link_valid_d;
  word_t link_addr_q, link_addr_d;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_done) begin
      link_valid_d = 1'b1;
      link_addr_d  = ll_addr;
    end
    // Clear is evaluated last so it overrides a set in the same cycle.
    if ((wr_done && (wr_addr == link_addr_d)) || sc_done) begin
      link_valid_d = 1'b0;
    end
    if (!LINK_EN) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign sc_ok = link_valid_q && (link_addr_q == wr_addr);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data requester, with LL/SC link support.
// Latency: >=2 cycles request->completion (grant cycle + ACCESS cycle); failed SC exactly 2.
// Backpressure: requester held with iwait/dwait=1 until RAM reports ACCESS; dropping the request aborts.
//
// Ports:
//   CLK, nRST                   clock / async active-low reset
//   iREN, iaddr -> iwait, iload instruction fetch request / completion
//   dREN, dWEN, datomic, daddr, dstore -> dwait, dload   data request / completion
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate  RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4,
  parameter bit LINK_EN        = 1'b1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  logic      datomic,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t         state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic               op_atomic_q, op_atomic_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic               d_req;
  logic               d_active;
  logic               op_sc;
  logic               d_done;
  logic               i_done;
  logic               sc_ok;
  logic               sc_fail_req;
  logic               burst_limit;
  logic [BURST_W-1:0] burst_inc;

  assign d_req    = dREN || dWEN;
  // The granted op stays live only while its own enable is held.
  assign d_active = op_wr_q ? dWEN : dREN;
  assign op_sc    = op_wr_q && op_atomic_q && LINK_EN;
  assign d_done   = (state_q == DATA)  && d_active && (ramstate == ACCESS);
  assign i_done   = (state_q == INSTR) && iREN     && (ramstate == ACCESS);

  assign sc_fail_req = dWEN && datomic && LINK_EN && !sc_ok;
  assign burst_limit = iREN && (burst_cnt_q == BURST_W'(MAX_DATA_BURST));
  assign burst_inc   = (burst_cnt_q == {BURST_W{1'b1}}) ? burst_cnt_q : burst_cnt_q + 1'b1;

  ll_sc_link #(
    .LINK_EN (LINK_EN)
  ) u_link (
    .clk     (CLK),
    .rst_n   (nRST),
    .ll_done (d_done && !op_wr_q && op_atomic_q),
    .ll_addr (daddr),
    .wr_done (d_done && op_wr_q),
    .wr_addr (daddr),
    .sc_done ((d_done && op_sc) || (state_q == SCFAIL)),
    .sc_ok   (sc_ok)
  );

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    op_atomic_d = op_atomic_q;
    burst_cnt_d = burst_cnt_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;

    unique case (state_q)
      IDLE: begin
        if (!iREN) begin
          burst_cnt_d = '0;
        end
        if (sc_fail_req) begin
          state_d = SCFAIL;
          if (iREN) burst_cnt_d = burst_inc;
        end else if (d_req && !burst_limit) begin
          state_d     = DATA;
          op_wr_d     = dWEN;
          op_atomic_d = datomic;
          if (iREN) burst_cnt_d = burst_inc;
        end else if (iREN) begin
          state_d     = INSTR;
          burst_cnt_d = '0;
        end
      end

      DATA: begin
        ramREN   = d_active && !op_wr_q;
        ramWEN   = d_active && op_wr_q;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_active) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          dload   = op_sc ? 32'd1 : ramload;
          state_d = IDLE;
        end
        // BUSY / FREE / ERROR: hold and keep retrying.
      end

      INSTR: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (i_done) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end

      SCFAIL: begin
        dwait   = 1'b0;
        dload   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      op_atomic_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      op_atomic_q <= op_atomic_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
